// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode field layout, sign extension.
package cpu_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fetch_state_t;

  // Opcode field for the default 16-bit instruction word; it always occupies
  // the top OPC_W bits of the word, whatever the word width.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Sign-extend the low w bits of v to 32 bits (1 <= w <= 32).
  function automatic logic [31:0] sext(input logic [31:0] v, input int w);
    logic signed [31:0] t;
    t = $signed(v << (32 - w));
    return t >>> (32 - w);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction memory fetch bus: req held until ack, data valid with ack.
interface pc_fetch_unit_if #(
  parameter int PW = 8,
  parameter int IW = 16
);
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit_pc_next_calc.sv
// Next-PC computation; pure combinational so a branch predictor can reuse it.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int PW   = 8,
  parameter int OFFW = 8
) (
  input  logic [PW-1:0]   pc,
  input  logic [OFFW-1:0] offset,
  input  logic            pc_incr,
  input  logic            pc_relbranch,
  output logic [PW-1:0]   pc_next
);

  logic [PW-1:0] off_ext;

  // Branch wins over increment; neither means stay put (halt idiom).
  always_comb begin
    off_ext = PW'(sext(32'(offset), OFFW));
    pc_next = pc;
    if (pc_relbranch)  pc_next = pc + off_ext;
    else if (pc_incr)  pc_next = pc + PW'(1);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner: fetches one word per step, holds it for the decoder,
// then updates the PC from the decoder's increment/branch decision.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PW       = 8,
  parameter int IW       = 16,
  parameter int OFFW     = 8,
  parameter int RESET_PC = 0,
  parameter int CW       = 16
) (
  input  logic                 clock,
  input  logic                 nReset,
  pc_fetch_unit_if.master      imem,
  input  logic                 stall,
  input  logic                 PCincr,
  input  logic                 PCrelbranch,
  output logic [IW-1:0]        instr,
  output logic [OPC_W-1:0]     opcode,
  output logic                 instr_valid,
  output logic [CW-1:0]        retired
);

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d, pc_next;
  logic [IW-1:0] instr_q, instr_d;
  logic [CW-1:0] retired_q, retired_d;

  pc_next_calc #(.PW(PW), .OFFW(OFFW)) u_next (
    .pc           (pc_q),
    .offset       (instr_q[OFFW-1:0]),
    .pc_incr      (PCincr),
    .pc_relbranch (PCrelbranch),
    .pc_next      (pc_next)
  );

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= FETCH;
      pc_q      <= PW'(RESET_PC);
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Next state: wait for ack in FETCH, wait for !stall in EXEC.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = imem.imem_ack ? EXEC : FETCH;
      EXEC:    state_d = stall ? EXEC : FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Datapath: latch word on ack; on leaving EXEC update PC and retire.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: if (imem.imem_ack) instr_d = imem.imem_rdata;
      EXEC: if (!stall) begin
        pc_d      = pc_next;
        retired_d = (&retired_q) ? retired_q : retired_q + CW'(1);
      end
      default: ;
    endcase
  end

  // Outputs decode from registers only; req is also killed by reset directly
  // so it drops the moment reset asserts rather than at the next edge.
  always_comb begin
    imem.imem_req  = (state_q == FETCH) && nReset;
    imem.imem_addr = pc_q;
    instr_valid    = (state_q == EXEC);
    instr          = instr_q;
    opcode         = instr_q[IW-1 -: OPC_W];
    retired        = retired_q;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder. Owns the program counter and fetches one instruction per step from instruction memory over a req/ack handshake.
- Presents the 3-bit opcode and the full instruction word to the decoder.
- Updates the PC from the decoder's PCincr/PCrelbranch outputs, using a sign-extended relative offset taken from the instruction word.

Parameters:
- PW, 8, program counter / instruction address width
- IW, 16, instruction word width; opcode is bits [IW-1:IW-3]
- OFFW, 8, branch offset width; offset is bits [OFFW-1:0], two's complement
- RESET_PC, 0, PC value loaded on reset
- CW, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held high until ack
- imem_addr  out  PW  fetch address (equals PC)
- imem_ack  in  1  memory accepts the request and returns data this cycle
- imem_rdata  in  IW  instruction word, valid when imem_ack=1
- stall  in  1  hold the current instruction in execute
- PCincr  in  1  from decoder: PC <= PC+1
- PCrelbranch  in  1  from decoder: PC <= PC + sext(offset)
- instr  out  IW  latched instruction word
- opcode  out  3  instr[IW-1:IW-3], to decoder
- instr_valid  out  1  instr/opcode are valid and being executed
- retired  out  CW  count of completed instructions, saturating

Behaviour:
- Reset (nReset=0, asynchronous):
  - state=FETCH; PC=RESET_PC; instr=0; retired=0.
  - imem_req, instr_valid, opcode forced to 0 immediately, without waiting for a clock edge.
  - On release, the first rising edge is an ordinary FETCH cycle.
- FSM state FETCH:
  - imem_req=1; imem_addr=PC; instr_valid=0.
  - imem_ack=0: stay in FETCH; req and addr held stable.
  - imem_ack=1: instr<=imem_rdata at that edge; go to EXEC.
  - imem_ack is ignored whenever req=0.
- FSM state EXEC:
  - instr_valid=1; imem_req=0; decoder outputs are sampled combinationally in this cycle.
  - stall=1: stay in EXEC; PC, instr and retired unchanged; instr_valid stays 1.
  - stall=0: apply the PC update below, retired<=retired+1 (saturating at all-ones), go to FETCH.
- PC update, all arithmetic modulo 2^PW:
  - PCrelbranch=1: PC <= PC + sign_extend(instr[OFFW-1:0]) to PW bits. The offset is relative to the branch's own address. This has priority even if PCincr=1.
  - PCincr=1, PCrelbranch=0: PC <= PC+1.
  - Both 0: PC unchanged. The same address is refetched; this is the defined halt idiom.
- Wrap-around:
  - PC = 2^PW-1 with PCincr gives 0.
  - A negative offset below 0 wraps to the top of the address space.
  - No error flag is raised in either case.
- Latency:
  - Minimum 2 cycles per instruction: FETCH with immediate ack, then EXEC.
  - First imem_req is visible in the first cycle after reset deassertion.
- Reset in mid-operation:
  - Reset during FETCH with ack pending: the request is abandoned and the returned data is not latched.
  - Reset during EXEC: no PC update or retire occurs.
- Outputs change only on clock edges or on reset assertion; there are no combinational paths from inputs to outputs.
- States are encoded as an enum; an illegal state recovers to FETCH.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {FETCH, EXEC}
  - opcode field position constants (OPC_MSB, OPC_LSB)
  - a sign-extend function used by both this block and the ALU/immediate path
- The existing opcode/ALU-code include files stay unchanged.
- One sub-module is natural: pc_next_calc, a pure combinational block with inputs PC, offset, PCincr, PCrelbranch and output next PC, shared with any future branch predictor.

Test Plan:
- Reset release, memory acks immediately, words 0x1000..0x1003 with opcode ADD -> addr sequence 0,1,2,3; instr_valid every second cycle; retired=4 after 8 cycles.
- Ack delayed 3 cycles at addr 5 -> imem_req held high with addr=5 for 4 cycles; instr latched only on the ack cycle; no PC change meanwhile.
- EXEC at PC=0x10, PCrelbranch=1, offset=0xFC (-4) -> next fetch addr 0x0C. At PC=0x02 with offset -4 -> next fetch addr 0xFE.
- PC=0xFF with PCincr=1 -> next fetch addr 0x00. PCincr=PCrelbranch=1 with offset 0x03 at PC=0x20 -> next fetch addr 0x23.
- stall=1 for 5 cycles in EXEC -> instr_valid and opcode stable, PC and retired unchanged; on stall=0 the update is applied once.
- nReset pulsed low mid-FETCH with ack arriving in the same cycle -> imem_req low immediately, instr stays 0, PC=RESET_PC; fetch restarts at RESET_PC.
